// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse input conditioner.
package mouse_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_t;

  localparam int unsigned SCREEN_X_MAX = 32'd1023;
  localparam int unsigned SCREEN_Y_MAX = 32'd767;

  localparam int unsigned BTN_LEFT   = 32'd0;
  localparam int unsigned BTN_RIGHT  = 32'd1;
  localparam int unsigned BTN_MIDDLE = 32'd2;

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: two-flop synchroniser followed by a debounce / click / long-press FSM.
module btn_debounce_fsm
  import mouse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 32'd65000,
  parameter int unsigned LONG_PRESS_CYCLES = 32'd32500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic held,
  output logic click,
  output logic long_press,
  output logic press_evt
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 32'd1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 32'd1);
  localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_TGT  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  // Hold counting starts once debounce completes, so the long threshold is offset.
  localparam logic [HOLD_W-1:0] HOLD_TGT = HOLD_W'(LONG_PRESS_CYCLES - DEBOUNCE_CYCLES);

  logic [1:0]        sync_q, sync_d;
  logic              s;
  btn_state_t        state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d, deb_inc_s;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc_s;
  logic              deb_done_s, hold_hit_s;
  logic              long_flag_q, long_flag_d;
  logic              held_q, held_d;
  logic              click_q, click_d;
  logic              long_q, long_d;

  assign s          = sync_q[1];
  assign deb_inc_s  = deb_cnt_q + DEB_ONE;
  assign deb_done_s = (deb_inc_s == DEB_TGT);
  assign hold_inc_s = hold_cnt_q + HOLD_ONE;
  assign hold_hit_s = (hold_inc_s == HOLD_TGT) && !long_flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b00;
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      held_q      <= 1'b0;
      click_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
      held_q      <= held_d;
      click_q     <= click_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    sync_d      = {sync_q[0], btn_raw};
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_flag_d = long_flag_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d   = DEB_PRESS;
          deb_cnt_d = DEB_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
        end else if (deb_done_s) begin
          state_d     = PRESSED;
          deb_cnt_d   = deb_inc_s;
          hold_cnt_d  = '0;
          long_flag_d = 1'b0;
        end else begin
          deb_cnt_d = deb_inc_s;
        end
      end
      // A falling s wins over the long threshold in the same cycle.
      PRESSED: begin
        if (!s) begin
          state_d   = DEB_RELEASE;
          deb_cnt_d = DEB_ONE;
        end else begin
          hold_cnt_d = (hold_cnt_q == HOLD_TGT) ? hold_cnt_q : hold_inc_s;
          if (hold_hit_s) begin
            long_flag_d = 1'b1;
          end else begin
            long_flag_d = long_flag_q;
          end
        end
      end
      DEB_RELEASE: begin
        if (s) begin
          state_d = PRESSED;
        end else if (deb_done_s) begin
          state_d   = IDLE;
          deb_cnt_d = deb_inc_s;
        end else begin
          deb_cnt_d = deb_inc_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    held_d    = held_q;
    click_d   = 1'b0;
    long_d    = 1'b0;
    press_evt = 1'b0;
    case (state_q)
      DEB_PRESS: begin
        if (s && deb_done_s) begin
          held_d    = 1'b1;
          press_evt = 1'b1;
        end else begin
          held_d = held_q;
        end
      end
      PRESSED: begin
        if (s && hold_hit_s) begin
          long_d = 1'b1;
        end else begin
          long_d = 1'b0;
        end
      end
      DEB_RELEASE: begin
        if (!s && deb_done_s) begin
          held_d  = 1'b0;
          click_d = !long_flag_q;
        end else begin
          held_d = held_q;
        end
      end
      IDLE: begin
        held_d = held_q;
      end
      default: begin
        held_d = 1'b0;
      end
    endcase
  end

  assign held       = held_q;
  assign click      = click_q;
  assign long_press = long_q;

endmodule

// File: rtl/mouse_click_ctl.sv
// Mouse input conditioner: per-button debounce/click/long-press, cursor clamp
// and capture of the cursor position at each debounced press.
module mouse_click_ctl
  import mouse_pkg::*;
#(
  parameter int unsigned N_BTN             = 32'd2,
  parameter int unsigned POS_W             = 32'd12,
  parameter int unsigned X_MAX             = SCREEN_X_MAX,
  parameter int unsigned Y_MAX             = SCREEN_Y_MAX,
  parameter int unsigned DEBOUNCE_CYCLES   = 32'd65000,
  parameter int unsigned LONG_PRESS_CYCLES = 32'd32500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [POS_W-1:0] xpos_raw,
  input  logic [POS_W-1:0] ypos_raw,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic [N_BTN-1:0] held,
  output logic [N_BTN-1:0] click,
  output logic [N_BTN-1:0] long_press,
  output logic [POS_W-1:0] press_x,
  output logic [POS_W-1:0] press_y
);

  localparam logic [POS_W-1:0] X_LIM = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_LIM = POS_W'(Y_MAX);

  logic [POS_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [POS_W-1:0] press_x_q, press_x_d, press_y_q, press_y_d;
  logic [N_BTN-1:0] press_evt_s;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_btn (
      .clk       (clk),
      .rst_n     (rst),
      .btn_raw   (btn_raw[i]),
      .held      (held[i]),
      .click     (click[i]),
      .long_press(long_press[i]),
      .press_evt (press_evt_s[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xpos_q    <= '0;
      ypos_q    <= '0;
      press_x_q <= '0;
      press_y_q <= '0;
    end else begin
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      press_x_q <= press_x_d;
      press_y_q <= press_y_d;
    end
  end

  // Simultaneous presses all sample the same xpos_q/ypos_q, so the lowest-index
  // winner is indistinguishable from any press at all.
  always_comb begin
    xpos_d = (xpos_raw > X_LIM) ? X_LIM : xpos_raw;
    ypos_d = (ypos_raw > Y_LIM) ? Y_LIM : ypos_raw;
    if (|press_evt_s) begin
      press_x_d = xpos_q;
      press_y_d = ypos_q;
    end else begin
      press_x_d = press_x_q;
      press_y_d = press_y_q;
    end
  end

  assign xpos    = xpos_q;
  assign ypos    = ypos_q;
  assign press_x = press_x_q;
  assign press_y = press_y_q;

endmodule
